// File: rtl/fetch_seq.sv
// Two-cycle fetch/execute sequencer: FETCH reads instruction memory,
// EXEC holds the word for the decoder and picks the next pc.
module fetch_seq #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] START_PC  = '0,
    parameter logic [15:0]       MAX_INSTR = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              halt,
    input  logic              branch_taken,
    input  logic [15:0]       branch_offset,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_q, rd_d;
    logic              vld_q, vld_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_br;
    logic [31:0]       off_ext;
    logic [15:0]       cnt_inc;

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign off_ext = {{16{branch_offset[15]}}, branch_offset};
    // Sum is formed wide and truncated so the target wraps modulo 2^ADDR_W.
    assign pc_br   = ADDR_W'(32'(pc_inc) + off_ext);
    assign cnt_inc = cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                end
            end
            FETCH: begin
                state_d = EXEC;
                instr_d = imem_rdata;
            end
            EXEC: begin
                cnt_d = cnt_inc;
                if (halt) begin
                    state_d = DONE;
                end else begin
                    pc_d = branch_taken ? pc_br : pc_inc;
                    if (cnt_inc == MAX_INSTR) begin
                        state_d = DONE;
                        tmo_d   = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == FETCH) || (state_d == EXEC);
        done_d = (state_d == DONE);
        rd_d   = (state_d == FETCH);
        vld_d  = (state_d == EXEC);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            instr_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            vld_q   <= vld_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = tmo_q;
    assign imem_rd     = rd_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = vld_q;
    assign pc          = pc_q;
    assign instr_count = cnt_q;

endmodule
